// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 4-bit ALU between two requesters. It accepts one operation at a
// time over a valid/ready handshake and registers the operands onto the alu_*
// drive. After ALU_LAT cycles it captures alu_out/alu_cout and returns them to
// the requester that issued the operation over a valid/ready response channel.
//
// Parameter
//   ALU_LAT      cycles from operands on alu_* to result on alu_out (1..7)
//
// Compile option
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie.
//                          undefined (default): round-robin on ties.
//
// Ports
//   clock, reset                  clock, synchronous active-high reset
//   reqN_valid/ready              operation handshake (ready is combinational)
//   reqN_sel/a/b/cin              operation fields
//   rspN_valid/ready              response handshake
//   rspN_data/cout                captured ALU result
//   alu_sel/a/b/cin               registered operand drive to the ALU
//   alu_out/alu_cout              ALU result inputs
//   busy                          high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_sel,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_cin,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_sel,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_cin,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [3:0] rsp0_data,
    output logic       rsp0_cout,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp1_data,
    output logic       rsp1_cout,
    output logic [2:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    input  logic [3:0] alu_out,
    input  logic       alu_cout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t     state;
    state_t     state_next;
    logic       owner;        // 1: requester 1 owns the in-flight operation
    logic [2:0] cnt;
    logic       grant1;
    logic       owner_take;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic       last_grant;   // requester granted most recently
`endif

    assign busy       = (state != IDLE);
    assign owner_take = owner ? rsp1_ready : rsp0_ready;

    // Next-state and request-ready decode
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (reset) begin
                    state_next = IDLE;
                end else if (req0_valid || req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    grant1 = req1_valid & ~req0_valid;
`else
                    // On a tie, requester 1 wins only if 0 was served last
                    grant1 = req1_valid & (~req0_valid | ~last_grant);
`endif
                    req0_ready = ~grant1;
                    req1_ready = grant1;
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE: begin
                if (owner_take) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand drive, latency counter and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= 3'd0;
            alu_sel    <= 3'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_cin    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= 4'd0;
            rsp0_cout  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= 4'd0;
            rsp1_cout  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        alu_sel <= req1_ready ? req1_sel : req0_sel;
                        alu_a   <= req1_ready ? req1_a   : req0_a;
                        alu_b   <= req1_ready ? req1_b   : req0_b;
                        alu_cin <= req1_ready ? req1_cin : req0_cin;
                        owner   <= req1_ready;
                        cnt     <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (owner) begin
                            rsp1_valid <= 1'b1;
                            rsp1_data  <= alu_out;
                            rsp1_cout  <= alu_cout;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_data  <= alu_out;
                            rsp0_cout  <= alu_cout;
                        end
                    end
                end
                DONE: begin
                    if (owner_take) begin
                        if (owner) begin
                            rsp1_valid <= 1'b0;
                        end else begin
                            rsp0_valid <= 1'b0;
                        end
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= owner;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. Two instances: dut (ALU_LAT=1) driven
// by a 4-bit adder model, and dut3 (ALU_LAT=3) driven by an adder followed by
// two pipeline registers, so its result appears ALU_LAT cycles after the
// operands. Expected grants and results come from a transaction-level model:
// winner from the valid pattern and last-granted requester, result = a+b+cin.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       req0_valid, req0_ready, req0_cin;
    logic [2:0] req0_sel;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [2:0] req1_sel;
    logic [3:0] req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp0_cout;
    logic [3:0] rsp0_data;
    logic       rsp1_valid, rsp1_ready, rsp1_cout;
    logic [3:0] rsp1_data;
    logic [2:0] alu_sel;
    logic [3:0] alu_a, alu_b, alu_out;
    logic       alu_cin, alu_cout, busy;
    logic [4:0] sum1;

    logic       l3_req0_valid, l3_req0_ready, l3_req0_cin;
    logic [2:0] l3_req0_sel;
    logic [3:0] l3_req0_a, l3_req0_b;
    logic       l3_req1_valid, l3_req1_ready, l3_req1_cin;
    logic [2:0] l3_req1_sel;
    logic [3:0] l3_req1_a, l3_req1_b;
    logic       l3_rsp0_valid, l3_rsp0_ready, l3_rsp0_cout;
    logic [3:0] l3_rsp0_data;
    logic       l3_rsp1_valid, l3_rsp1_ready, l3_rsp1_cout;
    logic [3:0] l3_rsp1_data;
    logic [2:0] l3_alu_sel;
    logic [3:0] l3_alu_a, l3_alu_b, l3_alu_out;
    logic       l3_alu_cin, l3_alu_cout, l3_busy;
    logic [4:0] l3_sum, l3_pipe0, l3_pipe1;

    int checks = 0;
    int errors = 0;
    int last_grant = 1;

    alu_arbiter #(.ALU_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .busy(busy)
    );

    alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_sel(l3_req0_sel),
        .req0_a(l3_req0_a), .req0_b(l3_req0_b), .req0_cin(l3_req0_cin),
        .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_sel(l3_req1_sel),
        .req1_a(l3_req1_a), .req1_b(l3_req1_b), .req1_cin(l3_req1_cin),
        .rsp0_valid(l3_rsp0_valid), .rsp0_ready(l3_rsp0_ready), .rsp0_data(l3_rsp0_data), .rsp0_cout(l3_rsp0_cout),
        .rsp1_valid(l3_rsp1_valid), .rsp1_ready(l3_rsp1_ready), .rsp1_data(l3_rsp1_data), .rsp1_cout(l3_rsp1_cout),
        .alu_sel(l3_alu_sel), .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_cin(l3_alu_cin),
        .alu_out(l3_alu_out), .alu_cout(l3_alu_cout), .busy(l3_busy)
    );

    // Adder ALU models
    assign sum1     = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    assign alu_out  = sum1[3:0];
    assign alu_cout = sum1[4];

    assign l3_sum      = {1'b0, l3_alu_a} + {1'b0, l3_alu_b} + {4'd0, l3_alu_cin};
    assign l3_alu_out  = l3_pipe1[3:0];
    assign l3_alu_cout = l3_pipe1[4];

    always @(posedge clock) begin
        l3_pipe0 <= l3_sum;
        l3_pipe1 <= l3_pipe0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic v0, input logic v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - last_grant;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic do_op(input logic v0, input logic v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic c0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic c1,
                         input int bp);
        int w;
        logic [2:0] s0, s1, es;
        logic [3:0] ea, eb;
        logic       ec;
        logic [4:0] exp;
        s0 = 3'($urandom);
        s1 = 3'($urandom);
        w  = pick_winner(v0, v1);
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        ec = (w == 1) ? c1 : c0;
        es = (w == 1) ? s1 : s0;
        exp = {1'b0, ea} + {1'b0, eb} + {4'd0, ec};

        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_sel = s1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check_val("idle_busy", busy, 1'b0);
        check_val("grant0", req0_ready, (w == 0));
        check_val("grant1", req1_ready, (w == 1));

        @(negedge clock);
        check_val("alu_a", alu_a, ea);
        check_val("alu_b", alu_b, eb);
        check_val("alu_sel", alu_sel, es);
        check_val("alu_cin", alu_cin, ec);
        check_val("wait_busy", busy, 1'b1);
        check_val("wait_rdy", {req0_ready, req1_ready}, 2'b00);
        check_val("wait_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        if (w == 0) rsp1_ready = 1'($urandom);
        else        rsp0_ready = 1'($urandom);

        @(negedge clock);
        check_val("rsp_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1'b1);
        check_val("rsp_other", (w == 0) ? rsp1_valid : rsp0_valid, 1'b0);
        check_val("rsp_data", (w == 0) ? rsp0_data : rsp1_data, exp[3:0]);
        check_val("rsp_cout", (w == 0) ? rsp0_cout : rsp1_cout, exp[4]);
        check_val("done_rdy", {req0_ready, req1_ready}, 2'b00);

        for (int k = 0; k < bp; k++) begin
            @(negedge clock);
            check_val("bp_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1'b1);
            check_val("bp_data", (w == 0) ? rsp0_data : rsp1_data, exp[3:0]);
            check_val("bp_busy", busy, 1'b1);
            check_val("bp_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        if (w == 0) rsp0_ready = 1'b1;
        else        rsp1_ready = 1'b1;

        @(negedge clock);
        check_val("after_busy", busy, 1'b0);
        check_val("after_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1'b0);
        check_val("after_hold", (w == 0) ? rsp0_data : rsp1_data, exp[3:0]);
        last_grant = w;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            #1;
            check_val("idle_rdy", {req0_ready, req1_ready}, 2'b00);
            check_val("idle_busy", busy, 1'b0);
            @(negedge clock);
        end
    endtask

    task automatic reset_mid_op();
        req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'h6; req0_cin = 1'b1; req0_sel = 3'd5;
        req1_valid = 1'b0;
        #1;
        check_val("mid_grant", req0_ready, 1'b1);
        @(negedge clock);
        check_val("mid_busy", busy, 1'b1);
        reset = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clock);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        check_val("mid_rst_alu", {alu_sel, alu_a, alu_b, alu_cin}, 12'd0);
        check_val("mid_rst_rdy", {req0_ready, req1_ready}, 2'b00);
        reset = 1'b0; req0_valid = 1'b0;
        last_grant = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_val("mid_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic lat3_op();
        l3_req1_valid = 1'b1; l3_req1_a = 4'hF; l3_req1_b = 4'h1; l3_req1_cin = 1'b1; l3_req1_sel = 3'd2;
        #1;
        check_val("lat3_grant", l3_req1_ready, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            l3_req1_valid = 1'b0;
            check_val("lat3_early", l3_rsp1_valid, 1'b0);
        end
        @(negedge clock);
        check_val("lat3_valid", l3_rsp1_valid, 1'b1);
        check_val("lat3_data", l3_rsp1_data, 4'h1);
        check_val("lat3_cout", l3_rsp1_cout, 1'b1);
        check_val("lat3_other", l3_rsp0_valid, 1'b0);
        l3_rsp1_ready = 1'b1;
        @(negedge clock);
        check_val("lat3_idle", l3_busy, 1'b0);
        l3_rsp1_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'd0; req0_a = 4'd0; req0_b = 4'd0; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_sel = 3'd0; req1_a = 4'd0; req1_b = 4'd0; req1_cin = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        l3_req0_valid = 1'b0; l3_req0_sel = 3'd0; l3_req0_a = 4'd0; l3_req0_b = 4'd0; l3_req0_cin = 1'b0;
        l3_req1_valid = 1'b0; l3_req1_sel = 3'd0; l3_req1_a = 4'd0; l3_req1_b = 4'd0; l3_req1_cin = 1'b0;
        l3_rsp0_ready = 1'b0; l3_rsp1_ready = 1'b0;

        repeat (3) @(negedge clock);
        check_val("rst_rdy", {req0_ready, req1_ready}, 2'b00);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rsp", {rsp0_valid, rsp0_data, rsp0_cout, rsp1_valid, rsp1_data, rsp1_cout}, 12'd0);
        check_val("rst_alu", {alu_sel, alu_a, alu_b, alu_cin}, 12'd0);
        reset = 1'b0;

        // Contention from reset release: expected 0,1,0,1 (0,0,0,0 fixed priority)
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), 1'($urandom), 0);
        end

        do_op(1'b1, 1'b0, 4'h3, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 0);   // 3+5 = 8
        do_op(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 4'h1, 1'b1, 0);   // F+1+1 = 1, carry
        do_op(1'b1, 1'b1, 4'hA, 4'h7, 1'b0, 4'h2, 4'h4, 1'b1, 5);   // backpressure
        idle_cycles(3);
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            int vv;
            vv = $urandom_range(1, 3);
            do_op(vv[0], vv[1], 4'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
        idle_cycles(1);

        lat3_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
